// File: rtl/seq_stage_controller.sv
// seq_stage_controller: multi-cycle stage sequencer for the Y86-64 sequential
// datapath. Walks each instruction through FETCH/DECODE/EXEC/MEM/WB with
// one-cycle stage strobes. It waits on the data-memory handshake with a
// timeout, traps halt, invalid-instruction and address faults, and counts
// retired instructions.
module seq_stage_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic [3:0]       icode_i,
    input  logic             instr_valid_i,
    input  logic             imem_error_i,
    input  logic             mem_ready_i,
    input  logic             dmem_error_i,
    output logic             fetch_en_o,
    output logic             decode_en_o,
    output logic             exec_en_o,
    output logic             mem_en_o,
    output logic             wb_en_o,
    output logic             pc_en_o,
    output logic [3:0]       cur_icode_o,
    output logic [2:0]       state_o,
    output logic [2:0]       stat_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] instr_count_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam int              WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT);

    state_t            state_q, state_d;
    logic [2:0]        stat_q, stat_d;
    logic [3:0]        cur_icode_q, cur_icode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              is_mem;

    // Instructions that actually touch data memory and must handshake in MEM
    always_comb begin
        is_mem = 1'b0;
        case (cur_icode_q)
            4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11: is_mem = 1'b1;
            default:                              is_mem = 1'b0;
        endcase
    end

    // State register: all sequencer state, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            stat_q      <= STAT_AOK;
            cur_icode_q <= 4'd0;
            cnt_q       <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            stat_q      <= stat_d;
            cur_icode_q <= cur_icode_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
        end
    end

    // Next-state logic: stage sequencing, fault trapping, memory wait/timeout
    always_comb begin
        state_d     = state_q;
        stat_d      = stat_q;
        cur_icode_d = cur_icode_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                cur_icode_d = icode_i;
                // imem_error outranks an invalid encoding; halt still retires
                if (imem_error_i) begin
                    state_d = S_HALTED;
                    stat_d  = STAT_ADR;
                end else if (!instr_valid_i) begin
                    state_d = S_HALTED;
                    stat_d  = STAT_INS;
                end else if (icode_i == 4'd0) begin
                    state_d = S_HALTED;
                    stat_d  = STAT_HLT;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_MEM;
                wait_d  = WAIT_W'(1);
            end
            S_MEM: begin
                if (!is_mem) begin
                    state_d = S_WB;
                    wait_d  = '0;
                end else if (mem_ready_i) begin
                    // ready in the final allowed cycle still counts
                    wait_d  = '0;
                    state_d = dmem_error_i ? S_HALTED : S_WB;
                    if (dmem_error_i) stat_d = STAT_ADR;
                end else if (wait_q == WAIT_LIM) begin
                    wait_d  = '0;
                    state_d = S_HALTED;
                    stat_d  = STAT_ADR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = run_i ? S_FETCH : S_IDLE;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        fetch_en_o    = (state_q == S_FETCH);
        decode_en_o   = (state_q == S_DECODE);
        exec_en_o     = (state_q == S_EXEC);
        mem_en_o      = (state_q == S_MEM) && is_mem;
        wb_en_o       = (state_q == S_WB);
        pc_en_o       = (state_q == S_WB);
        busy_o        = (state_q != S_IDLE) && (state_q != S_HALTED);
        state_o       = state_q;
        stat_o        = stat_q;
        cur_icode_o   = cur_icode_q;
        instr_count_o = cnt_q;
    end

endmodule

// File: tb/tb_seq_stage_controller.sv
// Self-checking bench for seq_stage_controller. A scoreboard queue holds the
// expected (cur_icode, instr_count) for each retirement and is popped on wb_en.
module tb_seq_stage_controller;
    localparam int CW = 4;
    localparam int TO = 15;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_HALTED = 3'd6;

    logic          clk = 1'b0, rst_n = 1'b0, run = 1'b0;
    logic [3:0]    icode = 4'd0;
    logic          instr_valid = 1'b0, imem_error = 1'b0, mem_ready = 1'b0, dmem_error = 1'b0;
    logic          fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, busy;
    logic [3:0]    cur_icode;
    logic [2:0]    state, stat;
    logic [CW-1:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [3:0] ic; logic [CW-1:0] cnt; } exp_t;
    exp_t          sb[$];
    logic [CW-1:0] exp_cnt = '0;

    seq_stage_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run_i(run), .icode_i(icode),
        .instr_valid_i(instr_valid), .imem_error_i(imem_error),
        .mem_ready_i(mem_ready), .dmem_error_i(dmem_error),
        .fetch_en_o(fetch_en), .decode_en_o(decode_en), .exec_en_o(exec_en),
        .mem_en_o(mem_en), .wb_en_o(wb_en), .pc_en_o(pc_en),
        .cur_icode_o(cur_icode), .state_o(state), .stat_o(stat),
        .busy_o(busy), .instr_count_o(instr_count)
    );

    always #5 clk = ~clk;

    // Per-cycle monitor: strobe exclusivity, busy decode, scoreboard on retire
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            n_tests++;
            if ($countones({fetch_en, decode_en, exec_en, mem_en, wb_en}) > 1 || pc_en !== wb_en ||
                busy !== (state != S_IDLE && state != S_HALTED)) begin
                n_fail++;
                $display("FAIL strobes: f%b d%b e%b m%b w%b p%b busy%b state=%0d", fetch_en, decode_en,
                         exec_en, mem_en, wb_en, pc_en, busy, state);
            end
            if (wb_en) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_wb: wb_en=1 with icode=%0d, none expected", cur_icode);
                end else begin
                    e = sb.pop_front();
                    if (cur_icode !== e.ic || instr_count !== e.cnt) begin
                        n_fail++;
                        $display("FAIL retire: got icode=%0d cnt=%0d, want icode=%0d cnt=%0d",
                                 cur_icode, instr_count, e.ic, e.cnt);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [3:0] ic);
        sb.push_back('{ic, exp_cnt});
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; dmem_error = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        sb.delete();
    endtask

    // Drive one instruction from IDLE until it settles in IDLE or HALTED
    task automatic run_one(input logic [3:0] ic, input logic iv, input logic ime, input int ready_at,
                           input logic dme, input logic [2:0] drop_st,
                           output int total, output int memc, output int wbc);
        int mc;
        bit started;
        total = 0; memc = 0; wbc = 0; mc = 0; started = 0;
        icode = ic; instr_valid = iv; imem_error = ime; dmem_error = dme; mem_ready = 1'b0; run = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (state == S_FETCH) started = 1;
            if (started && (state == S_IDLE || state == S_HALTED)) break;
            if (state != S_IDLE) total++;
            if (mem_en) memc++;
            if (wb_en) wbc++;
            if (state == drop_st) run = 1'b0;
            if (state == S_MEM) begin
                mc++;
                if (mc == ready_at) mem_ready = 1'b1;
            end
        end
        run = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_tests++;
        if (state !== S_IDLE || stat !== 3'd1 || instr_count !== '0 || cur_icode !== 4'd0 || busy !== 1'b0 ||
            {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset: state=%0d stat=%0d cnt=%0d icode=%0d busy=%b, want 0/1/0/0/0", state, stat,
                     instr_count, cur_icode, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_opq;
        logic [4:0] got [5];
        logic [4:0] expv[5];
        expv[0] = 5'b10000; expv[1] = 5'b01000; expv[2] = 5'b00100; expv[3] = 5'b00000; expv[4] = 5'b00001;
        icode = 4'd6; instr_valid = 1'b1; imem_error = 1'b0;
        push_exp(4'd6);
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got[i] = {fetch_en, decode_en, exec_en, mem_en, wb_en};
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (got[i] !== expv[i]) begin
                n_fail++;
                $display("FAIL opq_strobe%0d: got %b, want %b", i, got[i], expv[i]);
            end
        end
        @(negedge clk);
        n_tests++;
        if (state !== S_FETCH || instr_count !== 4'd1) begin
            n_fail++;
            $display("FAIL opq_next: state=%0d cnt=%0d, want 1/1", state, instr_count);
        end
        push_exp(4'd6);
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state == S_IDLE) break;
        end
        n_tests++;
        if (state !== S_IDLE || instr_count !== 4'd2) begin
            n_fail++;
            $display("FAIL opq_idle: state=%0d cnt=%0d, want 0/2", state, instr_count);
        end
    endtask

    task automatic test_mrmovq;
        int total, memc, wbc;
        push_exp(4'd5);
        run_one(4'd5, 1'b1, 1'b0, 3, 1'b0, S_FETCH, total, memc, wbc);
        n_tests++;
        if (total != 7 || memc != 3 || wbc != 1 || state !== S_IDLE || stat !== 3'd1 || instr_count !== 4'd3) begin
            n_fail++;
            $display("FAIL mrmovq: total=%0d memc=%0d wbc=%0d state=%0d stat=%0d cnt=%0d, want 7/3/1/0/1/3",
                     total, memc, wbc, state, stat, instr_count);
        end
    endtask

    task automatic test_timeout;
        int total, memc, wbc;
        do_reset();
        run_one(4'd10, 1'b1, 1'b0, 0, 1'b0, S_FETCH, total, memc, wbc);
        n_tests++;
        if (total != 3 + TO || memc != TO || wbc != 0 || state !== S_HALTED || stat !== 3'd3 || instr_count !== 4'd0) begin
            n_fail++;
            $display("FAIL timeout: total=%0d memc=%0d wbc=%0d state=%0d stat=%0d cnt=%0d, want %0d/%0d/0/6/3/0",
                     total, memc, wbc, state, stat, instr_count, 3 + TO, TO);
        end
        do_reset();
        push_exp(4'd10);
        run_one(4'd10, 1'b1, 1'b0, TO, 1'b0, S_FETCH, total, memc, wbc);
        n_tests++;
        if (total != 4 + TO || memc != TO || wbc != 1 || state !== S_IDLE || stat !== 3'd1 || instr_count !== 4'd1) begin
            n_fail++;
            $display("FAIL ready_last: total=%0d memc=%0d wbc=%0d state=%0d stat=%0d cnt=%0d, want %0d/%0d/1/0/1/1",
                     total, memc, wbc, state, stat, instr_count, 4 + TO, TO);
        end
        do_reset();
        run_one(4'd4, 1'b1, 1'b0, 2, 1'b1, S_FETCH, total, memc, wbc);
        n_tests++;
        if (memc != 2 || wbc != 0 || state !== S_HALTED || stat !== 3'd3 || instr_count !== 4'd0) begin
            n_fail++;
            $display("FAIL dmem_err: memc=%0d wbc=%0d state=%0d stat=%0d cnt=%0d, want 2/0/6/3/0",
                     memc, wbc, state, stat, instr_count);
        end
    endtask

    task automatic test_fetch_faults;
        int total, memc, wbc, bad;
        do_reset();
        run_one(4'd7, 1'b0, 1'b0, 0, 1'b0, S_FETCH, total, memc, wbc);
        n_tests++;
        if (total != 1 || state !== S_HALTED || stat !== 3'd4 || cur_icode !== 4'd7 || instr_count !== 4'd0) begin
            n_fail++;
            $display("FAIL ins: total=%0d state=%0d stat=%0d icode=%0d cnt=%0d, want 1/6/4/7/0",
                     total, state, stat, cur_icode, instr_count);
        end
        do_reset();
        run_one(4'd6, 1'b0, 1'b1, 0, 1'b0, S_FETCH, total, memc, wbc);
        n_tests++;
        if (state !== S_HALTED || stat !== 3'd3 || instr_count !== 4'd0) begin
            n_fail++;
            $display("FAIL imem: state=%0d stat=%0d cnt=%0d, want 6/3/0", state, stat, instr_count);
        end
        do_reset();
        run_one(4'd0, 1'b1, 1'b0, 0, 1'b0, S_FETCH, total, memc, wbc);
        n_tests++;
        if (state !== S_HALTED || stat !== 3'd2 || instr_count !== 4'd1 || wbc != 0) begin
            n_fail++;
            $display("FAIL halt: state=%0d stat=%0d cnt=%0d wbc=%0d, want 6/2/1/0", state, stat, instr_count, wbc);
        end
        run = 1'b1; bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state !== S_HALTED || stat !== 3'd2 || {fetch_en, decode_en, exec_en, mem_en, wb_en} !== 5'b0) bad++;
        end
        run = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL halt_sticky: %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_run_drop;
        int total, memc, wbc;
        do_reset();
        push_exp(4'd3);
        run_one(4'd3, 1'b1, 1'b0, 0, 1'b0, S_EXEC, total, memc, wbc);
        n_tests++;
        if (total != 5 || wbc != 1 || state !== S_IDLE || instr_count !== 4'd1) begin
            n_fail++;
            $display("FAIL run_drop: total=%0d wbc=%0d state=%0d cnt=%0d, want 5/1/0/1", total, wbc, state, instr_count);
        end
        push_exp(4'd3);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        n_tests++;
        if (state !== S_FETCH) begin
            n_fail++;
            $display("FAIL rerun: state=%0d, want 1", state);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state == S_IDLE) break;
        end
        n_tests++;
        if (state !== S_IDLE || instr_count !== 4'd2) begin
            n_fail++;
            $display("FAIL rerun_done: state=%0d cnt=%0d, want 0/2", state, instr_count);
        end
    endtask

    task automatic test_back_to_back;
        int fetches, gaps;
        logic [2:0] prev;
        do_reset();
        icode = 4'd6; instr_valid = 1'b1; imem_error = 1'b0;
        run = 1'b1; fetches = 0; gaps = 0; prev = S_IDLE;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (prev == S_WB && state != S_FETCH && fetches < 17) gaps++;
            if (state == S_FETCH) begin
                push_exp(4'd6);
                fetches++;
                if (fetches == 17) run = 1'b0;
            end
            prev = state;
            if (fetches == 17 && state == S_IDLE) break;
        end
        run = 1'b0;
        n_tests++;
        if (gaps != 0 || fetches != 17 || state !== S_IDLE || instr_count !== 4'd1 || stat !== 3'd1) begin
            n_fail++;
            $display("FAIL b2b_wrap: gaps=%0d fetches=%0d state=%0d cnt=%0d stat=%0d, want 0/17/0/1/1",
                     gaps, fetches, state, instr_count, stat);
        end
    endtask

    task automatic test_reset_mid_mem;
        int total, memc, wbc, seen;
        do_reset();
        push_exp(4'd6);
        run_one(4'd6, 1'b1, 1'b0, 0, 1'b0, S_FETCH, total, memc, wbc);
        icode = 4'd8; instr_valid = 1'b1; mem_ready = 1'b0; run = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (state == S_MEM) seen++;
            if (seen == 3) break;
        end
        n_tests++;
        if (seen != 3 || mem_en !== 1'b1 || instr_count !== 4'd1) begin
            n_fail++;
            $display("FAIL pre_reset: mem_cycles=%0d mem_en=%b cnt=%0d, want 3/1/1", seen, mem_en, instr_count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (state !== S_IDLE || instr_count !== '0 || mem_en !== 1'b0 || busy !== 1'b0 || stat !== 3'd1 ||
            cur_icode !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d cnt=%0d mem_en=%b busy=%b stat=%0d icode=%0d, want 0/0/0/0/1/0",
                     state, instr_count, mem_en, busy, stat, cur_icode);
        end
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (state !== S_IDLE || sb.size() != 0 || instr_count !== '0) begin
            n_fail++;
            $display("FAIL post_reset: state=%0d pending=%0d cnt=%0d, want 0/0/0", state, sb.size(), instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_opq();
        test_mrmovq();
        test_timeout();
        test_fetch_faults();
        test_run_drop();
        test_back_to_back();
        test_reset_mid_mem();
        repeat (2) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d retirements never seen, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_stage_controller.md
# seq_stage_controller

Multi-cycle stage sequencer for the Y86-64 sequential datapath. It steps each instruction through Fetch, Decode, Execute, Memory and Write-back by issuing one-cycle stage-enable strobes. The write-back strobe gates the register file's negedge write port. It waits on the data-memory handshake, detects halt, invalid-instruction and address-error conditions, and reports Y86 status codes and a retired-instruction count.

## Interface
Parameters:
- MEM_TIMEOUT, 15, max Memory-stage cycles without mem_ready before an ADR fault (≥1)
- CNT_W, 32, width of instr_count

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; permits starting/continuing instruction execution
- icode  in  4  instruction code from fetch logic, valid while fetch_en=1
- instr_valid  in  1  fetch logic recognises icode/ifun, valid while fetch_en=1
- imem_error  in  1  instruction-memory address error, valid while fetch_en=1
- mem_ready  in  1  data memory completes current access
- dmem_error  in  1  data-memory address error, sampled only with mem_ready=1
- fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en  out  1 each  stage strobes
- cur_icode  out  4  icode latched at end of FETCH
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6
- stat  out  3  AOK=1, HLT=2, ADR=3, INS=4
- busy  out  1  state ∉ {IDLE, HALTED}
- instr_count  out  CNT_W  retired instructions, wraps to 0

## Operation
- Moore outputs decoded from registered state: fetch_en=(FETCH), decode_en=(DECODE), exec_en=(EXEC), wb_en=pc_en=(WB).
- mem_en=(MEM) && cur_icode ∈ {4,5,8,9,10,11} (rmmovq, mrmovq, call, ret, pushq, popq). Other icodes: MEM lasts exactly one cycle, and mem_en stays 0.
- IDLE: run=1 → FETCH; else stay.
- FETCH: latch icode into cur_icode. Priority:
  - imem_error → HALTED, stat=ADR.
  - else !instr_valid → HALTED, stat=INS.
  - else icode=0 (halt) → HALTED, stat=HLT, instr_count+1.
  - else → DECODE.
- DECODE → EXEC → MEM unconditionally.
- MEM (memory icodes):
  - mem_ready=1 && dmem_error=1 → HALTED, stat=ADR.
  - mem_ready=1 && dmem_error=0 → WB.
  - else wait. Wait counter starts at 1 on MEM entry. If mem_ready is still 0 in the MEM_TIMEOUT-th cycle → HALTED, stat=ADR. Ready in that same cycle is accepted.
- MEM (non-memory icodes): → WB.
- WB: instr_count+1; run=1 → FETCH, else → IDLE.
- HALTED: sticky, all strobes 0; left only via rst_n.
- Faulting instructions (ADR/INS) never assert wb_en or pc_en and do not increment instr_count.
- stat changes only on entry to HALTED; otherwise AOK.
- cur_icode holds its value through IDLE and HALTED.

## Timing
- Reset (asynchronous, immediate): state=IDLE, all strobes 0, cur_icode=0, stat=AOK, busy=0, instr_count=0, wait counter=0.
- Reset mid-instruction abandons any pending memory access. No wb_en pulse is emitted.
- First FETCH is the cycle after run is sampled 1 in IDLE.
- Latency per instruction:
  - non-memory: exactly 5 cycles, FETCH to WB inclusive.
  - memory: 4 + N cycles, N = MEM cycles up to and including the mem_ready cycle (1..MEM_TIMEOUT).
- Back-to-back with run=1: FETCH immediately follows WB, no idle cycle.
- wb_en is high for one full clock cycle, so exactly one falling edge of clk falls inside it. The register file commits on that negedge.
- run deasserted mid-instruction: the current instruction completes through WB, then IDLE. run is sampled only in IDLE and WB.
- instr_count wraps from 2^CNT_W−1 to 0 without affecting stat.
- Strobes are mutually exclusive every cycle (one-hot or all zero).

## Test plan
- Reset then run=1 with OPq (icode=6, valid) → strobes fetch,decode,exec,(mem_en=0),wb/pc in 5 consecutive cycles; instr_count=1; next cycle FETCH.
- mrmovq (icode=5) with mem_ready asserted on 3rd MEM cycle → mem_en high 3 cycles, wb_en one cycle later, total 7 cycles; stat=AOK.
- pushq (icode=10), MEM_TIMEOUT=15, mem_ready never → HALTED after 15th MEM cycle, stat=3, no wb_en/pc_en, instr_count unchanged. Repeat with ready on cycle 15 → proceeds to WB.
- Fetch faults: instr_valid=0 → stat=4 HALTED; imem_error=1 with instr_valid=0 → stat=3 (imem_error priority); icode=0 → stat=2, instr_count+1. Verify HALTED persists with run=1 for 20 cycles.
- run dropped during EXEC of irmovq (icode=3) → instruction completes WB, state=IDLE; run reasserted → FETCH next cycle.
- rst_n pulsed low mid-MEM wait → all outputs reset asynchronously (before next edge); instr_count=0; state=IDLE; no wb_en observed.
